// File: rtl/auto_step_counter_if.sv
// rtl/auto_step_counter_if.sv - control and status bundle for the auto step counter
interface auto_step_counter_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  enable;
  logic                  pause;
  logic                  dir;
  logic                  mode;
  logic [WIDTH-1:0]      step;
  logic [WIDTH-1:0]      count;
  logic [4*DIGITS-1:0]   bcd;
  logic                  bcd_valid;
  logic                  count_reached;
  logic                  wrapped;
  logic                  tick;

  modport master (
    output enable, pause, dir, mode, step,
    input  count, bcd, bcd_valid, count_reached, wrapped, tick
  );

  modport slave (
    input  enable, pause, dir, mode, step,
    output count, bcd, bcd_valid, count_reached, wrapped, tick
  );
endinterface

// File: rtl/auto_step_counter.sv
// rtl/auto_step_counter.sv - tick-paced saturating/wrapping step counter with sequential BCD readout
module auto_step_counter #(
  parameter int WIDTH    = 8,
  parameter int CLK_FREQ = 50_000_000,
  parameter int TICK_HZ  = 1,
  parameter int LIMIT    = 150,
  parameter int DIGITS   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  auto_step_counter_if.slave    io
);
  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int DW  = $clog2(DIV);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int BW  = 4 * DIGITS;
  localparam longint WMAX = longint'(1) << WIDTH;
  localparam longint DMAX = longint'(10) ** DIGITS;
  localparam logic [WIDTH-1:0] LIM      = WIDTH'(LIMIT);
  localparam logic [DW-1:0]    DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0]    SHIFTS   = CW'(WIDTH);

  if ((LIMIT < 0) || (longint'(LIMIT) >= WMAX) || (longint'(LIMIT) >= DMAX) ||
      (DIV < WIDTH + 2)) begin : g_bad_params
    $error("auto_step_counter: illegal LIMIT/WIDTH/DIGITS/DIV combination");
  end

  typedef enum logic {CONV_IDLE, CONV_RUN} conv_e;

  conv_e            cs_q, cs_d;
  logic [DW-1:0]    div_q, div_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             reached_q, reached_d;
  logic             wrapped_q, wrapped_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]    work_q, work_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             valid_q, valid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] term, start;
  logic [BW-1:0]    adj;
  logic             load;

  always_comb begin
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    tick_d = (div_q == DIV_LAST);
  end

  always_comb begin
    term      = io.dir ? '0 : LIM;
    start     = io.dir ? LIM : '0;
    sum       = {1'b0, count_q} + {1'b0, io.step};
    count_d   = count_q;
    wrapped_d = 1'b0;
    if (!io.enable) begin
      count_d = start;
    end else if (!io.pause && tick_q) begin
      if (count_q == term) begin
        if (io.mode) begin
          count_d   = start;
          wrapped_d = 1'b1;
        end
      end else if (!io.dir) begin
        count_d = (sum >= {1'b0, LIM}) ? LIM : sum[WIDTH-1:0];
      end else begin
        count_d = (io.step >= count_q) ? '0 : count_q - io.step;
      end
    end
    reached_d = (count_d == term);
    load      = (count_d != count_q);
  end

  // Converter FSM: any count change (re)loads it, so a stale result is never committed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cs_q <= CONV_IDLE;
    else        cs_q <= cs_d;
  end

  always_comb begin
    cs_d = cs_q;
    if (load)                                   cs_d = CONV_RUN;
    else if (cs_q == CONV_RUN && cnt_q == SHIFTS) cs_d = CONV_IDLE;
  end

  always_comb begin
    bin_d   = bin_q;
    work_d  = work_q;
    bcd_d   = bcd_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    adj     = work_q;
    if (load) begin
      bin_d   = count_d;
      work_d  = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (cs_q == CONV_RUN) begin
      if (cnt_q == SHIFTS) begin
        bcd_d   = work_q;
        valid_d = 1'b1;
      end else begin
        for (int i = 0; i < DIGITS; i++) begin
          if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        work_d = {adj[BW-2:0], bin_q[WIDTH-1]};
        bin_d  = bin_q << 1;
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= '0;
      tick_q    <= 1'b0;
      count_q   <= '0;
      reached_q <= 1'b0;
      wrapped_q <= 1'b0;
      bin_q     <= '0;
      work_q    <= '0;
      bcd_q     <= '0;
      valid_q   <= 1'b1;
      cnt_q     <= '0;
    end else begin
      div_q     <= div_d;
      tick_q    <= tick_d;
      count_q   <= count_d;
      reached_q <= reached_d;
      wrapped_q <= wrapped_d;
      bin_q     <= bin_d;
      work_q    <= work_d;
      bcd_q     <= bcd_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign io.count         = count_q;
  assign io.bcd           = bcd_q;
  assign io.bcd_valid     = valid_q;
  assign io.count_reached = reached_q;
  assign io.wrapped       = wrapped_q;
  assign io.tick          = tick_q;
endmodule

// File: tb/tb_auto_step_counter.sv
// tb/tb_auto_step_counter.sv - table, directed and random checks of auto_step_counter against a behavioural model
module tb_auto_step_counter;
  localparam int WIDTH = 8, LIMIT = 150, DIGITS = 3, CLK_FREQ = 10, TICK_HZ = 1;
  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int LAT = WIDTH + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  auto_step_counter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) io ();

  auto_step_counter #(
    .WIDTH(WIDTH), .CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ), .LIMIT(LIMIT), .DIGITS(DIGITS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io(io.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: count as an integer, edges since reset, edges since the count last moved
  int m_count, m_cyc, m_age, m_shown;
  bit m_tick, m_reached, m_wrapped, m_valid;

  typedef struct {
    bit en, pause, dir, mode;
    int step, nticks, exp_count;
    bit exp_reached;
    int exp_bcd;
  } phase_t;
  phase_t tbl[15];

  function automatic int to_bcd(int v);
    int r = 0;
    for (int i = 0; i < DIGITS; i++) begin
      r = r | ((v % 10) << (4 * i));
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_cyc = 0; m_age = 1000; m_shown = 0;
    m_tick = 0; m_reached = 0; m_wrapped = 0; m_valid = 1;
  endtask

  task automatic model_step();
    int old, term, start;
    bit wr;
    old   = m_count;
    wr    = 0;
    term  = io.dir ? 0 : LIMIT;
    start = io.dir ? LIMIT : 0;
    if (!io.enable) m_count = start;
    else if (!io.pause && m_tick) begin
      if (m_count == term) begin
        if (io.mode) begin m_count = start; wr = 1; end
      end else if (!io.dir) m_count = (m_count + int'(io.step) >= LIMIT) ? LIMIT : m_count + int'(io.step);
      else m_count = (int'(io.step) >= m_count) ? 0 : m_count - int'(io.step);
    end
    m_reached = (m_count == term);
    m_wrapped = wr;
    m_cyc++;
    m_tick = (m_cyc % DIV == 0);
    if (m_count != old) m_age = 0;
    else if (m_age < 1000) m_age++;
    if (m_age == LAT) m_shown = to_bcd(m_count);
    m_valid = (m_age >= LAT);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("count", io.count, m_count);
    check("count_reached", io.count_reached, m_reached);
    check("wrapped", io.wrapped, m_wrapped);
    check("tick", io.tick, m_tick);
    check("bcd_valid", io.bcd_valid, m_valid);
    check("bcd", io.bcd, m_shown);
  endtask

  task automatic consume_ticks(input int n);
    int consumed, guard;
    bit t;
    consumed = 0;
    guard = 0;
    while (consumed < n && guard < (n + 2) * DIV) begin
      t = m_tick;
      cycle();
      if (t) consumed++;
      guard++;
    end
    check("tick_budget", consumed, n);
  endtask

  task automatic set_in(input bit en, input bit pause, input bit dir, input bit mode, input int step);
    io.enable = en; io.pause = pause; io.dir = dir; io.mode = mode; io.step = WIDTH'(step);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, io.count, 0);
    check({tag, "_bcd"}, io.bcd, 0);
    check({tag, "_bcd_valid"}, io.bcd_valid, 1);
    check({tag, "_reached"}, io.count_reached, 0);
    check({tag, "_wrapped"}, io.wrapped, 0);
    check({tag, "_tick"}, io.tick, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int first;
    tbl[0]  = '{0, 0, 0, 0,   4,  0,   0, 0, 'h000};
    tbl[1]  = '{1, 0, 0, 0,   4, 37, 148, 0, 'h148};
    tbl[2]  = '{1, 0, 0, 0,   4,  1, 150, 1, 'h150};
    tbl[3]  = '{1, 0, 0, 0,   4,  2, 150, 1, 'h150};
    tbl[4]  = '{1, 0, 0, 1,   4,  1,   0, 0, 'h000};
    tbl[5]  = '{1, 0, 0, 0,   4, 10,  40, 0, 'h040};
    tbl[6]  = '{1, 1, 0, 0,   4,  3,  40, 0, 'h040};
    tbl[7]  = '{1, 0, 0, 0,   4,  1,  44, 0, 'h044};
    tbl[8]  = '{0, 0, 1, 0,   7,  0, 150, 0, 'h150};
    tbl[9]  = '{1, 0, 1, 0,   7, 21,   3, 0, 'h003};
    tbl[10] = '{1, 0, 1, 0,   7,  1,   0, 1, 'h000};
    tbl[11] = '{1, 0, 0, 0,   0,  2,   0, 0, 'h000};
    tbl[12] = '{1, 0, 0, 0, 200,  1, 150, 1, 'h150};
    tbl[13] = '{1, 0, 1, 1, 255,  1,   0, 1, 'h000};
    tbl[14] = '{1, 0, 1, 1,   5,  1, 150, 0, 'h150};

    set_in(0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1 check_reset_outputs("por");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();

    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].en, tbl[i].pause, tbl[i].dir, tbl[i].mode, tbl[i].step);
      if (tbl[i].nticks == 0) repeat (DIV) cycle();
      else begin
        consume_ticks(tbl[i].nticks);
        repeat (LAT) cycle();
      end
      check($sformatf("row%0d_count", i), io.count, tbl[i].exp_count);
      check($sformatf("row%0d_reached", i), io.count_reached, tbl[i].exp_reached);
      check($sformatf("row%0d_bcd", i), io.bcd, tbl[i].exp_bcd);
      check($sformatf("row%0d_bcd_valid", i), io.bcd_valid, 1);
    end

    // Clear while 100 is still being converted: its image must never surface
    set_in(0, 0, 0, 0, 100);
    repeat (DIV) cycle();
    io.enable = 1'b1;
    consume_ticks(1);
    check("abort_pre_count", io.count, 100);
    repeat (3) cycle();
    check("abort_mid_valid", io.bcd_valid, 0);
    io.enable = 1'b0;
    cycle();
    check("abort_clr_count", io.count, 0);
    check("abort_clr_valid", io.bcd_valid, 0);
    for (int k = 1; k <= LAT; k++) begin
      cycle();
      check($sformatf("abort_valid_k%0d", k), io.bcd_valid, (k >= LAT) ? 1 : 0);
      check($sformatf("abort_no_stale_k%0d", k), (io.bcd_valid && io.bcd == 12'h100) ? 1 : 0, 0);
    end
    check("abort_bcd", io.bcd, 0);

    // Asynchronous reset mid-cycle at count 88, then first tick latency
    set_in(1, 0, 0, 0, 8);
    consume_ticks(11);
    repeat (4) cycle();
    check("areset_pre_count", io.count, 88);
    #4 reset = 1'b0;
    #1 check_reset_outputs("areset");
    model_reset();
    @(posedge clk);
    #1 check_reset_outputs("areset_hold");
    reset = 1'b1;
    first = -1;
    for (int k = 1; k <= DIV + 2; k++) begin
      cycle();
      if (io.tick && first < 0) first = k;
    end
    check("first_tick_latency", first, DIV);

    for (int i = 0; i < 2000; i++) begin
      io.enable = ($urandom % 24) != 0;
      io.pause  = ($urandom % 10) == 0;
      if ($urandom % 100 == 0) io.dir  = ~io.dir;
      if ($urandom % 40 == 0)  io.mode = ~io.mode;
      if ($urandom % 50 == 0)  io.step = WIDTH'(($urandom % 4 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 20));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
